tcp_vlg_tx_arb: RTL and testbench
=================================

TCP_VLG_TX_ARB -- requirements
Module: tcp_vlg_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 100000, meaning max cycles in WAIT for tx_sent before abort.
REQ-002 SHALL have parameter FLAG_ACK, default 8'h10, meaning TCP flag byte used for pure ACK segments.
REQ-003 SHALL have parameter FLAG_PSH_ACK, default 8'h18, meaning TCP flag byte used for payload segments.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  in  1  connection teardown; clears all pending requests and aborts the current grant.
REQ-007 SHALL have port ctl_req  in  1  one-cycle pulse; engine requests a control segment (SYN/FIN/RST).
REQ-008 SHALL have port ctl_flags  in  8  flag byte for the control segment, sampled with ctl_req.
REQ-009 SHALL have port ack_req  in  1  one-cycle pulse; engine requests a pure ACK.
REQ-010 SHALL have port pld_send  in  1  one-cycle pulse from the TX buffer controller; a payload segment is ready.
REQ-011 SHALL have ports pld_seq  in  32, pld_lng  in  16, pld_cks  in  32  payload segment info, sampled with pld_send.
REQ-012 SHALL have port loc_seq  in  32  current local sequence number, used for control and ACK segments.
REQ-013 SHALL have ports tx_send  out  1, tx_flags  out  8, tx_seq  out  32, tx_lng  out  16, tx_cks  out  32  segment request to the TCP transmitter.
REQ-014 SHALL have port tx_sent  in  1  one-cycle pulse from the transmitter; the granted segment has left.
REQ-015 SHALL have ports ctl_done, ack_done, pld_sent  out  1 each  one-cycle completion pulses per requester.
REQ-016 SHALL have port tx_err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-017 SHALL latch each request pulse into its own pending flag (ctl_pend, ack_pend, pld_pend) at the edge where the pulse is high, together with its sampled info fields.
REQ-018 SHALL accept a new request of a given type while busy; a repeat request of the same type while pending SHALL overwrite the stored info (last wins), and SHALL NOT add a second entry.
REQ-019 SHALL implement FSM states IDLE, SEND, WAIT.
REQ-020 In IDLE with any pend flag set, the block SHALL select by fixed priority ctl > pld > ack, register the tx_* fields, and move to SEND.
REQ-021 In SEND, tx_send SHALL be high for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-022 Request-to-tx_send latency from IDLE SHALL be 2 cycles: request at cycle 0, pend at cycle 1, tx_send at cycle 2.
REQ-023 A ctl grant SHALL drive tx_flags=ctl_flags, tx_seq=loc_seq, tx_lng=0, tx_cks=0.
REQ-024 An ack grant SHALL drive tx_flags=FLAG_ACK, tx_seq=loc_seq, tx_lng=0, tx_cks=0.
REQ-025 A pld grant SHALL drive tx_flags=FLAG_PSH_ACK and the stored seq/lng/cks.
REQ-026 A pld grant SHALL also clear ack_pend, because the payload carries the ACK; ack_done SHALL NOT pulse in this case.
REQ-027 Granting a request SHALL clear its pend flag at the same edge the FSM enters SEND.
REQ-028 A request arriving in that same cycle SHALL re-set its pend flag; set wins over clear.
REQ-029 In WAIT, tx_sent SHALL pulse the done output of the granted type on the next cycle and return the FSM to IDLE.
REQ-030 tx_sent arriving outside WAIT SHALL be ignored.
REQ-031 A watchdog counter SHALL clear on entering WAIT. Reaching TIMEOUT_TICKS without tx_sent SHALL pulse tx_err, pulse no done output, and return the FSM to IDLE.
REQ-032 flush SHALL, at the next edge, clear all pend flags, force the FSM to IDLE and drop tx_send; it SHALL take precedence over simultaneous requests and tx_sent.

Reset
REQ-033 On rst the block SHALL set the FSM to IDLE and clear all pend flags and the watchdog.
REQ-034 On rst the block SHALL drive tx_send=0, tx_flags=0, tx_seq=0, tx_lng=0, tx_cks=0, ctl_done=0, ack_done=0, pld_sent=0 and tx_err=0.
REQ-035 Reset mid-WAIT SHALL discard the grant without any done or tx_err pulse.

Structure
REQ-036 The FSM state enum and the grant-type enum (ctl/ack/pld) SHALL live in tcp_vlg_pkg, alongside the existing tcp_num_t and length_t.
REQ-037 The watchdog SHALL be a sub-module named tcp_vlg_tx_wdog, with inputs clear/enable and output expire.

Verification
REQ-038 ack_req at cycle 0 -> tx_send at cycle 2 with tx_flags=8'h10 and tx_lng=0; tx_sent at cycle 5 -> ack_done at cycle 6.
REQ-039 ctl_req (flags 8'h02), pld_send and ack_req all in the same cycle -> ctl granted first; after tx_sent, pld granted with flags 8'h18; ack_done never pulses.
REQ-040 pld_send (seq 32'h1000, lng 100) while in WAIT on a ctl grant -> pld latched; after tx_sent, tx_send with tx_seq=32'h1000 and tx_lng=100.
REQ-041 TIMEOUT_TICKS=16 and no tx_sent -> tx_err pulses 16 cycles after entering WAIT; no pld_sent; FSM back in IDLE.
REQ-042 flush during WAIT with ack_pend set -> FSM IDLE next cycle, no done pulse, and a later tx_sent is ignored.
REQ-043 rst asserted mid-WAIT -> all outputs 0 immediately, asynchronously; no pulses after release.

Source files
------------

// File: rtl/tcp_vlg_pkg.sv
// Shared types for the TCP transmit path: sequence/length types plus the
// transmit arbiter's FSM state and grant-type enumerations.
package tcp_vlg_pkg;

    typedef logic [31:0] tcp_num_t;
    typedef logic [15:0] length_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        GNT_CTL,
        GNT_ACK,
        GNT_PLD
    } tx_gnt_t;

endpackage

// File: rtl/tcp_vlg_tx_wdog.sv
// Watchdog for the transmit arbiter: counts enabled cycles after a clear and
// flags expiry once TIMEOUT_TICKS cycles have elapsed without a clear.
module tcp_vlg_tx_wdog #(
    parameter int TIMEOUT_TICKS = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic [CW-1:0] count_reg;

    // expire is combinational so the owner can register its reaction on the
    // TIMEOUT_TICKS-th cycle of waiting
    assign expire = enable && (count_reg == CW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/tcp_vlg_tx_arb.sv
// Transmit arbiter: latches control, payload and ACK requests and hands them
// one at a time to the TCP transmitter with fixed priority ctl > pld > ack.
module tcp_vlg_tx_arb
    import tcp_vlg_pkg::*;
#(
    parameter int         TIMEOUT_TICKS = 100000,
    parameter logic [7:0] FLAG_ACK      = 8'h10,
    parameter logic [7:0] FLAG_PSH_ACK  = 8'h18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ctl_req,
    input  logic [7:0]  ctl_flags,
    input  logic        ack_req,
    input  logic        pld_send,
    input  logic [31:0] pld_seq,
    input  logic [15:0] pld_lng,
    input  logic [31:0] pld_cks,
    input  logic [31:0] loc_seq,
    output logic        tx_send,
    output logic [7:0]  tx_flags,
    output logic [31:0] tx_seq,
    output logic [15:0] tx_lng,
    output logic [31:0] tx_cks,
    input  logic        tx_sent,
    output logic        ctl_done,
    output logic        ack_done,
    output logic        pld_sent,
    output logic        tx_err
);

    tx_state_t  state_reg, state_next;
    tx_gnt_t    gnt_reg, gnt_next;
    logic       grant_go;
    logic       wdog_expire;

    logic       ctl_pend, ack_pend, pld_pend;
    logic [7:0] ctl_flags_reg;
    tcp_num_t   pld_seq_reg;
    length_t    pld_lng_reg;
    tcp_num_t   pld_cks_reg;

    tcp_vlg_tx_wdog #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg == TX_SEND),
        .enable (state_reg == TX_WAIT),
        .expire (wdog_expire)
    );

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        grant_go   = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                if (ctl_pend || pld_pend || ack_pend) begin
                    grant_go   = 1'b1;
                    state_next = TX_SEND;
                    if (ctl_pend)      gnt_next = GNT_CTL;
                    else if (pld_pend) gnt_next = GNT_PLD;
                    else               gnt_next = GNT_ACK;
                end
            end
            TX_SEND: state_next = TX_WAIT;
            TX_WAIT: if (tx_sent || wdog_expire) state_next = TX_IDLE;
            default: state_next = TX_IDLE;
        endcase
        if (flush) begin
            state_next = TX_IDLE;
            grant_go   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= TX_IDLE;
            gnt_reg   <= GNT_CTL;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_pend      <= 1'b0;
            ack_pend      <= 1'b0;
            pld_pend      <= 1'b0;
            ctl_flags_reg <= '0;
            pld_seq_reg   <= '0;
            pld_lng_reg   <= '0;
            pld_cks_reg   <= '0;
            tx_send       <= 1'b0;
            tx_flags      <= '0;
            tx_seq        <= '0;
            tx_lng        <= '0;
            tx_cks        <= '0;
            ctl_done      <= 1'b0;
            ack_done      <= 1'b0;
            pld_sent      <= 1'b0;
            tx_err        <= 1'b0;
        end else begin
            ctl_done <= 1'b0;
            ack_done <= 1'b0;
            pld_sent <= 1'b0;
            tx_err   <= 1'b0;
            tx_send  <= (state_next == TX_SEND);

            if (ctl_req)  ctl_flags_reg <= ctl_flags;
            if (pld_send) begin
                pld_seq_reg <= pld_seq;
                pld_lng_reg <= pld_lng;
                pld_cks_reg <= pld_cks;
            end

            if (grant_go) begin
                case (gnt_next)
                    GNT_CTL: begin
                        tx_flags <= ctl_flags_reg;
                        tx_seq   <= loc_seq;
                        tx_lng   <= '0;
                        tx_cks   <= '0;
                    end
                    GNT_PLD: begin
                        tx_flags <= FLAG_PSH_ACK;
                        tx_seq   <= pld_seq_reg;
                        tx_lng   <= pld_lng_reg;
                        tx_cks   <= pld_cks_reg;
                    end
                    default: begin
                        tx_flags <= FLAG_ACK;
                        tx_seq   <= loc_seq;
                        tx_lng   <= '0;
                        tx_cks   <= '0;
                    end
                endcase
            end

            if (!flush && state_reg == TX_WAIT) begin
                if (tx_sent) begin
                    ctl_done <= (gnt_reg == GNT_CTL);
                    ack_done <= (gnt_reg == GNT_ACK);
                    pld_sent <= (gnt_reg == GNT_PLD);
                end else if (wdog_expire) begin
                    tx_err <= 1'b1;
                end
            end

            // A fresh request pulse beats the clear from its own grant; a
            // payload grant also retires any pending ACK it piggybacks.
            if (flush) begin
                ctl_pend <= 1'b0;
                ack_pend <= 1'b0;
                pld_pend <= 1'b0;
            end else begin
                if (ctl_req)
                    ctl_pend <= 1'b1;
                else if (grant_go && gnt_next == GNT_CTL)
                    ctl_pend <= 1'b0;
                if (pld_send)
                    pld_pend <= 1'b1;
                else if (grant_go && gnt_next == GNT_PLD)
                    pld_pend <= 1'b0;
                if (ack_req)
                    ack_pend <= 1'b1;
                else if (grant_go && (gnt_next == GNT_ACK || gnt_next == GNT_PLD))
                    ack_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// Scoreboard bench for tcp_vlg_tx_arb: stimulus queues expected output events
// with their cycle numbers; a monitor pops and compares on every output pulse.
module tb_tcp_vlg_tx_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ctl_req = 1'b0;
    logic [7:0]  ctl_flags = '0;
    logic        ack_req = 1'b0;
    logic        pld_send = 1'b0;
    logic [31:0] pld_seq = '0;
    logic [15:0] pld_lng = '0;
    logic [31:0] pld_cks = '0;
    logic [31:0] loc_seq = '0;
    logic        tx_send;
    logic [7:0]  tx_flags;
    logic [31:0] tx_seq;
    logic [15:0] tx_lng;
    logic [31:0] tx_cks;
    logic        tx_sent = 1'b0;
    logic        ctl_done, ack_done, pld_sent, tx_err;

    tcp_vlg_tx_arb #(
        .TIMEOUT_TICKS(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ctl_req(ctl_req), .ctl_flags(ctl_flags), .ack_req(ack_req),
        .pld_send(pld_send), .pld_seq(pld_seq), .pld_lng(pld_lng), .pld_cks(pld_cks),
        .loc_seq(loc_seq),
        .tx_send(tx_send), .tx_flags(tx_flags), .tx_seq(tx_seq), .tx_lng(tx_lng), .tx_cks(tx_cks),
        .tx_sent(tx_sent),
        .ctl_done(ctl_done), .ack_done(ack_done), .pld_sent(pld_sent), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_SEND = 0, K_CTL = 1, K_ACK = 2, K_PLD = 3, K_ERR = 4;
    string kname [5] = '{"tx_send", "ctl_done", "ack_done", "pld_sent", "tx_err"};

    typedef struct {
        int          kind;
        logic [7:0]  flags;
        logic [31:0] seq;
        logic [15:0] lng;
        logic [31:0] cks;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [92:0] all_outs;
    assign all_outs = {tx_send, tx_flags, tx_seq, tx_lng, tx_cks, ctl_done, ack_done, pld_sent, tx_err};
    logic [4:0] ev_bits;
    assign ev_bits = {tx_err, pld_sent, ack_done, ctl_done, tx_send};

    task automatic chk(input string name, input logic [92:0] act, input logic [92:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int k, input logic [7:0] f, input logic [31:0] s,
                             input logic [15:0] l, input logic [31:0] c, input int at);
        exp_t e;
        e.kind = k; e.flags = f; e.seq = s; e.lng = l; e.cks = c; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL overdue_%s: got nothing by cycle %0d required at cycle %0d",
                         kname[e.kind], cyc, e.at);
            end
            for (int k = 0; k < 5; k++) begin
                if (ev_bits[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_%s: got pulse at cycle %0d required none", kname[k], cyc);
                    end else begin
                        exp_t e;
                        logic ok;
                        e = exp_q.pop_front();
                        checks++;
                        ok = (e.kind == k) && (e.at == cyc);
                        if (k == K_SEND)
                            ok = ok && (tx_flags === e.flags) && (tx_seq === e.seq)
                                    && (tx_lng === e.lng) && (tx_cks === e.cks);
                        if (!ok) begin
                            errors++;
                            $display("FAIL event_%s: got %s@%0d flags=%h seq=%h lng=%0d cks=%h required %s@%0d flags=%h seq=%h lng=%0d cks=%h",
                                     kname[e.kind], kname[k], cyc, tx_flags, tx_seq, tx_lng, tx_cks,
                                     kname[e.kind], e.at, e.flags, e.seq, e.lng, e.cks);
                        end else begin
                            $display("txn %s cycle=%0d flags=%h seq=%h lng=%0d cks=%h",
                                     kname[k], cyc, tx_flags, tx_seq, tx_lng, tx_cks);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        #3;
        chk("reset_outputs", all_outs, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("post_reset_outputs", all_outs, '0);

        // Pure ACK: latency 2, done the cycle after tx_sent
        c0 = cyc;
        loc_seq = 32'hA000_0001;
        ack_req = 1'b1;
        expect_ev(K_SEND, 8'h10, 32'hA000_0001, 16'd0, 32'd0, c0 + 2);
        tick();
        ack_req = 1'b0;
        wait_to(c0 + 5);
        tx_sent = 1'b1;
        expect_ev(K_ACK, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 6);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 10);

        // ctl, pld and ack together: ctl first, then pld absorbs the ACK
        c0 = cyc;
        loc_seq = 32'hB000_0002;
        ctl_req = 1'b1; ctl_flags = 8'h02;
        pld_send = 1'b1; pld_seq = 32'h2000; pld_lng = 16'd40; pld_cks = 32'h1234;
        ack_req = 1'b1;
        expect_ev(K_SEND, 8'h02, 32'hB000_0002, 16'd0, 32'd0, c0 + 2);
        tick();
        ctl_req = 1'b0; pld_send = 1'b0; ack_req = 1'b0;
        ctl_flags = 8'hFF; pld_seq = 32'hFFFF_FFFF;
        wait_to(c0 + 4);
        tx_sent = 1'b1;
        expect_ev(K_CTL, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 5);
        expect_ev(K_SEND, 8'h18, 32'h2000, 16'd40, 32'h1234, c0 + 6);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 8);
        tx_sent = 1'b1;
        expect_ev(K_PLD, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 9);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 16);

        // Payload latched while waiting on a ctl grant; second pulse wins
        c0 = cyc;
        loc_seq = 32'hC000_0003;
        ctl_req = 1'b1; ctl_flags = 8'h01;
        expect_ev(K_SEND, 8'h01, 32'hC000_0003, 16'd0, 32'd0, c0 + 2);
        tick();
        ctl_req = 1'b0;
        wait_to(c0 + 4);
        pld_send = 1'b1; pld_seq = 32'hDEAD; pld_lng = 16'd7; pld_cks = 32'h1;
        tick();
        pld_seq = 32'h1000; pld_lng = 16'd100; pld_cks = 32'h55AA;
        tick();
        pld_send = 1'b0;
        tx_sent = 1'b1;
        expect_ev(K_CTL, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 7);
        expect_ev(K_SEND, 8'h18, 32'h1000, 16'd100, 32'h55AA, c0 + 8);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 10);
        tx_sent = 1'b1;
        expect_ev(K_PLD, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 11);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 16);

        // Watchdog abort, then stray tx_sent in IDLE ignored, then normal ACK
        c0 = cyc;
        pld_send = 1'b1; pld_seq = 32'h3000; pld_lng = 16'd8; pld_cks = 32'h9;
        expect_ev(K_SEND, 8'h18, 32'h3000, 16'd8, 32'h9, c0 + 2);
        expect_ev(K_ERR, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 19);
        tick();
        pld_send = 1'b0;
        wait_to(c0 + 21);
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 23);
        loc_seq = 32'hD000_0004;
        ack_req = 1'b1;
        expect_ev(K_SEND, 8'h10, 32'hD000_0004, 16'd0, 32'd0, c0 + 25);
        tick();
        ack_req = 1'b0;
        wait_to(c0 + 27);
        tx_sent = 1'b1;
        expect_ev(K_ACK, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 28);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 32);

        // Flush in WAIT with ack pending and a simultaneous ctl request
        c0 = cyc;
        loc_seq = 32'hE000_0005;
        ctl_req = 1'b1; ctl_flags = 8'h04;
        expect_ev(K_SEND, 8'h04, 32'hE000_0005, 16'd0, 32'd0, c0 + 2);
        tick();
        ctl_req = 1'b0;
        wait_to(c0 + 3);
        ack_req = 1'b1;
        tick();
        ack_req = 1'b0;
        wait_to(c0 + 5);
        flush = 1'b1; ctl_req = 1'b1; ctl_flags = 8'h01;
        tick();
        flush = 1'b0; ctl_req = 1'b0;
        wait_to(c0 + 7);
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 20);
        ack_req = 1'b1;
        expect_ev(K_SEND, 8'h10, 32'hE000_0005, 16'd0, 32'd0, c0 + 22);
        tick();
        ack_req = 1'b0;
        wait_to(c0 + 24);
        tx_sent = 1'b1;
        expect_ev(K_ACK, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 25);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 30);

        // Repeat ACK request in the grant cycle re-arms the pend flag
        c0 = cyc;
        loc_seq = 32'hF000_0006;
        ack_req = 1'b1;
        expect_ev(K_SEND, 8'h10, 32'hF000_0006, 16'd0, 32'd0, c0 + 2);
        tick();
        tick();
        ack_req = 1'b0;
        wait_to(c0 + 4);
        tx_sent = 1'b1;
        expect_ev(K_ACK, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 5);
        expect_ev(K_SEND, 8'h10, 32'hF000_0006, 16'd0, 32'd0, c0 + 6);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 8);
        tx_sent = 1'b1;
        expect_ev(K_ACK, 8'h00, 32'd0, 16'd0, 32'd0, c0 + 9);
        tick();
        tx_sent = 1'b0;
        wait_to(c0 + 14);

        // Asynchronous reset mid-WAIT clears outputs at once; no pulses after
        c0 = cyc;
        pld_send = 1'b1; pld_seq = 32'h5000; pld_lng = 16'd20; pld_cks = 32'h77;
        expect_ev(K_SEND, 8'h18, 32'h5000, 16'd20, 32'h77, c0 + 2);
        tick();
        pld_send = 1'b0;
        wait_to(c0 + 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs, '0);
        tick();
        tick();
        chk("held_reset_outputs", all_outs, '0);
        rst = 1'b0;
        tick();
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        repeat (20) tick();
        chk("idle_after_reset", all_outs, '0);

        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        chk("scoreboard_drained", 93'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
